// File: rtl/execute_multdiv.sv
// rtl/execute_multdiv.sv - iterative signed multiply/divide unit for the execute stage
// One bit per cycle: shift-add multiply or restoring divide on magnitudes, sign fixed at the end.
module execute_multdiv #(
  parameter int WIDTH        = 32,
  parameter int MUL_EXC_CODE = 4,
  parameter int DIV_EXC_CODE = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             kill,
  output logic             busy,
  output logic             stall,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             exception
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MUL_CODE = WIDTH'(MUL_EXC_CODE);
  localparam logic [WIDTH-1:0] DIV_CODE = WIDTH'(DIV_EXC_CODE);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state_q;
  logic [CW-1:0]        cnt_q;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     op_q;
  logic                 neg_q, div_q, ovf_q;
  logic [WIDTH-1:0]     result_q;
  logic                 valid_q, exc_q;

  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH:0]       sum, trial;
  logic [2*WIDTH-1:0]   prod_s;
  logic [WIDTH-1:0]     quo_s;
  logic                 mul_ovf;

  assign mag_a = operand_a[WIDTH-1] ? -operand_a : operand_a;
  assign mag_b = operand_b[WIDTH-1] ? -operand_b : operand_b;

  // acc_q holds {partial product, multiplier} for multiply and {remainder, dividend/quotient} for divide.
  always_comb begin
    acc_d = acc_q;
    sum   = '0;
    trial = '0;
    if (div_q) begin
      trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, op_q};
      if (trial[WIDTH]) acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
      else              acc_d = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, op_q} : '0);
      acc_d = {sum, acc_q[WIDTH-1:1]};
    end
  end

  assign prod_s  = neg_q ? -acc_d : acc_d;
  assign quo_s   = neg_q ? -acc_d[WIDTH-1:0] : acc_d[WIDTH-1:0];
  assign mul_ovf = (prod_s[2*WIDTH-1:WIDTH-1] != '0) && (prod_s[2*WIDTH-1:WIDTH-1] != '1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      div_q    <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= '0;
      valid_q  <= 1'b0;
      exc_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          valid_q <= 1'b0;
          if (start && !kill) begin
            neg_q <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
            div_q <= is_div;
            cnt_q <= '0;
            op_q  <= is_div ? mag_b : mag_a;
            acc_q <= {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
            ovf_q <= is_div && (operand_a == MIN_VAL) && (operand_b == '1);
            if (is_div && (operand_b == '0)) begin
              state_q  <= DONE;
              result_q <= DIV_CODE;
              exc_q    <= 1'b1;
              valid_q  <= 1'b1;
            end else begin
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          if (kill) begin
            state_q <= IDLE;
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
              state_q <= DONE;
              valid_q <= 1'b1;
              if (div_q) begin
                exc_q    <= ovf_q;
                result_q <= ovf_q ? DIV_CODE : quo_s;
              end else begin
                exc_q    <= mul_ovf;
                result_q <= mul_ovf ? MUL_CODE : prod_s[WIDTH-1:0];
              end
            end
          end
        end
        DONE: begin
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy         = (state_q != IDLE);
  assign stall        = ((state_q == IDLE) && start && !kill) || (state_q == RUN);
  assign result       = result_q;
  assign result_valid = valid_q;
  assign exception    = exc_q;

endmodule
